vote_arbiter: RTL



---
 rtl/vote_pkg.sv | 21 ++
 rtl/vote_arbiter_if.sv | 28 ++
 rtl/vote_arbiter_majority3.sv | 7 +
 rtl/vote_arbiter.sv | 92 +++++++++
 4 files changed

// File: rtl/vote_pkg.sv
// Shared definitions for the vote arbiter: default sizes, slot state encoding
// and the index-width helper.
package vote_pkg;

  localparam int unsigned NREQ_DEF  = 4;
  localparam int unsigned CNT_W_DEF = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

  // Bits needed to index n requesters; never less than one.
  function automatic int unsigned vote_clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/vote_arbiter_if.sv
// Requester and response channels of the vote arbiter, plus the ones counter.
interface vote_arbiter_if #(
  parameter int unsigned NREQ  = vote_pkg::NREQ_DEF,
  parameter int unsigned CNT_W = vote_pkg::CNT_W_DEF
);
  localparam int unsigned ID_W = vote_pkg::vote_clog2(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [3*NREQ-1:0] req_vote;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [ID_W-1:0]   rsp_id;
  logic              rsp_out;
  logic [CNT_W-1:0]  ones_cnt;

  // Requesters and response consumer.
  modport master (
    output req_valid, req_vote, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_out, ones_cnt
  );

  // The arbiter itself.
  modport slave (
    input  req_valid, req_vote, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_out, ones_cnt
  );
endinterface

// File: rtl/vote_arbiter_majority3.sv
// Combinational 2-of-3 majority of a vote word.
module majority3 (
  input  logic [2:0] vote,
  output logic       maj_c
);
  assign maj_c = (vote[0] & vote[1]) | (vote[0] & vote[2]) | (vote[1] & vote[2]);
endmodule

// File: rtl/vote_arbiter.sv
// Round-robin arbiter feeding one shared majority voter into a one-entry
// response slot, with a saturating count of "1" results.
module vote_arbiter
  import vote_pkg::*;
#(
  parameter int unsigned NREQ  = NREQ_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         resetn,
  vote_arbiter_if.slave bus
);
  localparam int unsigned      ID_W    = vote_clog2(NREQ);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [ID_W-1:0]  LAST_ID = ID_W'(NREQ - 1);

  slot_state_e      state;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  rsp_id_q;
  logic             rsp_out_q;
  logic [CNT_W-1:0] ones_cnt_q;

  logic             free;
  logic             gnt;
  logic [ID_W-1:0]  gnt_idx;
  logic [ID_W-1:0]  cand;
  logic [NREQ-1:0]  ready;
  logic [2:0]       vote_sel;
  logic             maj_c;

  // Slot can take a word if empty or draining this cycle; nothing is granted in reset.
  assign free = resetn & ((state == EMPTY) | bus.rsp_ready);

  // Round-robin search starting at ptr, wrapping at NREQ-1.
  always_comb begin
    gnt     = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    ready   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = ID_W'((32'(ptr) + k) % NREQ);
      if (!gnt && free && bus.req_valid[cand]) begin
        gnt     = 1'b1;
        gnt_idx = cand;
      end
    end
    if (gnt) ready[gnt_idx] = 1'b1;
  end

  // Grant mux into the single shared voter.
  always_comb begin
    vote_sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (ID_W'(i) == gnt_idx) vote_sel = bus.req_vote[3*i +: 3];
    end
  end

  majority3 u_majority3 (
    .vote  (vote_sel),
    .maj_c (maj_c)
  );

  // Slot state, response payload, pointer and counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= EMPTY;
      ptr        <= '0;
      rsp_id_q   <= '0;
      rsp_out_q  <= 1'b0;
      ones_cnt_q <= '0;
    end else begin
      case (state)
        EMPTY:   if (gnt) state <= FULL;
        FULL:    if (bus.rsp_ready && !gnt) state <= EMPTY;
        default: state <= EMPTY;
      endcase
      if (gnt) begin
        ptr       <= (gnt_idx == LAST_ID) ? '0 : gnt_idx + ID_W'(1);
        rsp_id_q  <= gnt_idx;
        rsp_out_q <= maj_c;
        if (maj_c && (ones_cnt_q != CNT_MAX)) ones_cnt_q <= ones_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.req_ready = ready;
  assign bus.rsp_valid = (state == FULL);
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_out   = rsp_out_q;
  assign bus.ones_cnt  = ones_cnt_q;

endmodule
